// File: rtl/quadencoder_index_ctrl_if.sv
// Index-search control bus between a host and quadencoder_index_ctrl.
interface quadencoder_index_ctrl_if #(
  parameter int unsigned BITS         = 32,
  parameter int unsigned TIMEOUT_BITS = 24
);
  logic                     arm;
  logic                     abort;
  logic [TIMEOUT_BITS-1:0]  timeout_cycles;
  logic                     indexout_in;
  logic signed [BITS-1:0]   position_in;
  logic                     indexenable_out;
  logic                     busy;
  logic                     done;
  logic                     timed_out;
  logic signed [BITS-1:0]   latched_position;
  logic [15:0]              index_count;

  modport master (
    output arm, abort, timeout_cycles, indexout_in, position_in,
    input  indexenable_out, busy, done, timed_out, latched_position, index_count
  );

  modport slave (
    input  arm, abort, timeout_cycles, indexout_in, position_in,
    output indexenable_out, busy, done, timed_out, latched_position, index_count
  );
endinterface

// File: rtl/quadencoder_index_ctrl.sv
// Quadrature encoder index search controller: arms the encoder's index reset,
// waits for the index to fire, captures the pre-reset count and reports it.
module quadencoder_index_ctrl #(
  parameter int unsigned BITS           = 32,
  parameter int unsigned TIMEOUT_BITS   = 24,
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  quadencoder_index_ctrl_if.slave bus
);

  localparam int unsigned REL_W      = (RELEASE_CYCLES > 2) ? $clog2(RELEASE_CYCLES) : 1;
  localparam int unsigned REL_LAST_I = (RELEASE_CYCLES > 1) ? RELEASE_CYCLES - 1 : 0;
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_LAST_I);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    WAIT_Z  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    indexenable_q, indexenable_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    timed_out_q, timed_out_d;
  logic signed [BITS-1:0]  latched_position_q, latched_position_d;
  logic signed [BITS-1:0]  shadow_q, shadow_d;
  logic [15:0]             index_count_q, index_count_d;
  logic [TIMEOUT_BITS-1:0] tmr_q, tmr_d;
  logic                    tmr_en_q, tmr_en_d;
  logic [REL_W-1:0]        rel_q, rel_d;
  logic                    expire_c;

  // Timer is on its last cycle: the search expires at the coming edge.
  assign expire_c = tmr_en_q && (tmr_q == TIMEOUT_BITS'(1));

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d            = state_q;
    indexenable_d      = indexenable_q;
    done_d             = 1'b0;
    timed_out_d        = 1'b0;
    latched_position_d = latched_position_q;
    shadow_d           = shadow_q;
    index_count_d      = index_count_q;
    tmr_d              = tmr_q;
    tmr_en_d           = tmr_en_q;
    rel_d              = rel_q;

    if (((state_q == ARM) || (state_q == WAIT_Z)) && tmr_en_q) begin
      tmr_d = tmr_q - TIMEOUT_BITS'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.arm && !bus.abort) begin
          state_d       = ARM;
          indexenable_d = 1'b1;
          tmr_d         = bus.timeout_cycles;
          tmr_en_d      = (bus.timeout_cycles != '0);
        end
      end
      ARM: begin
        if (bus.abort || expire_c) begin
          state_d       = RELEASE;
          indexenable_d = 1'b0;
          rel_d         = '0;
          timed_out_d   = !bus.abort;
        end else if (bus.indexout_in) begin
          state_d = WAIT_Z;
        end
      end
      WAIT_Z: begin
        shadow_d = bus.position_in;
        // Abort beats index fall, and index fall beats timeout expiry.
        if (bus.abort || !bus.indexout_in || expire_c) begin
          state_d       = RELEASE;
          indexenable_d = 1'b0;
          rel_d         = '0;
          if (!bus.abort) begin
            if (!bus.indexout_in) begin
              done_d             = 1'b1;
              latched_position_d = shadow_q;
              index_count_d      = index_count_q + 16'd1;
            end else begin
              timed_out_d = 1'b1;
            end
          end
        end
      end
      RELEASE: begin
        if (rel_q == REL_LAST) begin
          state_d = IDLE;
        end else begin
          rel_d = rel_q + REL_W'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        indexenable_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops indexenable immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      indexenable_q      <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      timed_out_q        <= 1'b0;
      latched_position_q <= '0;
      shadow_q           <= '0;
      index_count_q      <= '0;
      tmr_q              <= '0;
      tmr_en_q           <= 1'b0;
      rel_q              <= '0;
    end else begin
      state_q            <= state_d;
      indexenable_q      <= indexenable_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      timed_out_q        <= timed_out_d;
      latched_position_q <= latched_position_d;
      shadow_q           <= shadow_d;
      index_count_q      <= index_count_d;
      tmr_q              <= tmr_d;
      tmr_en_q           <= tmr_en_d;
      rel_q              <= rel_d;
    end
  end

  assign bus.indexenable_out  = indexenable_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.timed_out        = timed_out_q;
  assign bus.latched_position = latched_position_q;
  assign bus.index_count      = index_count_q;

endmodule

// File: tb/tb_quadencoder_index_ctrl.sv
// Self-checking bench for quadencoder_index_ctrl with a pulse scoreboard.
module tb_quadencoder_index_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  quadencoder_index_ctrl_if #(.BITS(32), .TIMEOUT_BITS(24)) qif ();

  quadencoder_index_ctrl #(
    .BITS(32), .TIMEOUT_BITS(24), .RELEASE_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (qif)
  );

  typedef struct {
    logic        is_done;
    logic [31:0] pos;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic is_done, input logic [31:0] pos, input logic [15:0] cnt);
    exp_t e;
    e.is_done = is_done;
    e.pos     = pos;
    e.cnt     = cnt;
    sb_q.push_back(e);
  endtask

  // Every done/timed_out pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && (qif.done || qif.timed_out)) begin
      check_eq("pulse_excl", 32'(qif.done & qif.timed_out), 0);
      if (sb_q.size() == 0) begin
        check_eq("unexpected_pulse", 32'({qif.done, qif.timed_out}), 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("pulse_kind_done", 32'(qif.done), 32'(e.is_done));
        check_eq("sb_latched", 32'(qif.latched_position), e.pos);
        check_eq("sb_count", 32'(qif.index_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    qif.arm = 1'b0;
    qif.abort = 1'b0;
    qif.timeout_cycles = '0;
    qif.indexout_in = 1'b0;
    qif.position_in = '0;
    tick(2);
    check_eq("rst_flags", 32'({qif.indexenable_out, qif.busy, qif.done, qif.timed_out}), 0);
    check_eq("rst_latched", 32'(qif.latched_position), 0);
    check_eq("rst_count", 32'(qif.index_count), 0);
    rst = 1'b0;
    tick(1);

    // Normal search, no timeout, position ramps to 1234 before index fires.
    qif.arm = 1'b1;
    tick(1);
    qif.arm = 1'b0;
    check_eq("norm_ie_on", 32'(qif.indexenable_out), 1);
    check_eq("norm_busy", 32'(qif.busy), 1);
    qif.arm = 1'b1;
    tick(1);
    qif.arm = 1'b0;
    tick(1);
    qif.indexout_in = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      qif.position_in = 32'(1204 + 10 * i);
      tick(1);
    end
    qif.indexout_in = 1'b0;
    qif.position_in = '0;
    push_exp(1'b1, 32'd1234, 16'd1);
    tick(1);
    check_eq("norm_ie_off0", 32'(qif.indexenable_out), 0);
    check_eq("norm_busy_rel0", 32'(qif.busy), 1);
    tick(1);
    check_eq("norm_ie_off1", 32'(qif.indexenable_out), 0);
    check_eq("norm_busy_rel1", 32'(qif.busy), 1);
    tick(1);
    check_eq("norm_idle", 32'(qif.busy), 0);

    // Timeout of 10 cycles with the index never arriving.
    qif.timeout_cycles = 24'd10;
    qif.arm = 1'b1;
    tick(1);
    qif.arm = 1'b0;
    push_exp(1'b0, 32'd1234, 16'd1);
    n = 0;
    while (!qif.timed_out && n < 50) begin
      tick(1);
      n++;
    end
    check_eq("tmo_latency", 32'(n), 10);
    check_eq("tmo_ie_off", 32'(qif.indexenable_out), 0);
    tick(2);
    check_eq("tmo_idle", 32'(qif.busy), 0);

    // Index fall lands on the same cycle as timeout expiry: index wins.
    qif.timeout_cycles = 24'd5;
    qif.arm = 1'b1;
    tick(1);
    qif.arm = 1'b0;
    qif.indexout_in = 1'b1;
    tick(1);
    qif.position_in = 32'd500;
    tick(1);
    qif.position_in = 32'd600;
    tick(1);
    qif.position_in = 32'd777;
    tick(1);
    qif.indexout_in = 1'b0;
    qif.position_in = '0;
    push_exp(1'b1, 32'd777, 16'd2);
    tick(1);
    check_eq("race_no_tmo", 32'(qif.timed_out), 0);
    check_eq("race_count", 32'(qif.index_count), 2);
    tick(2);

    // Abort together with index fall; arm during release is dropped.
    qif.timeout_cycles = '0;
    qif.arm = 1'b1;
    tick(1);
    qif.arm = 1'b0;
    qif.indexout_in = 1'b1;
    qif.position_in = 32'd900;
    tick(2);
    qif.abort = 1'b1;
    qif.indexout_in = 1'b0;
    tick(1);
    qif.abort = 1'b0;
    check_eq("abort_ie_off", 32'(qif.indexenable_out), 0);
    check_eq("abort_busy", 32'(qif.busy), 1);
    qif.arm = 1'b1;
    tick(1);
    qif.arm = 1'b0;
    tick(1);
    check_eq("abort_idle", 32'(qif.busy), 0);
    tick(1);
    check_eq("abort_arm_dropped", 32'({qif.busy, qif.indexenable_out}), 0);
    check_eq("abort_latched", 32'(qif.latched_position), 32'd777);
    check_eq("abort_count", 32'(qif.index_count), 2);

    // Arm and abort together in IDLE does not start a search.
    qif.arm = 1'b1;
    qif.abort = 1'b1;
    tick(1);
    qif.arm = 1'b0;
    qif.abort = 1'b0;
    check_eq("armabort_nostart", 32'({qif.busy, qif.indexenable_out}), 0);

    // Counter wrap from 0xFFFF to 0x0000 on the next completed search.
    force dut.index_count_q = 16'hFFFF;
    tick(1);
    release dut.index_count_q;
    check_eq("wrap_preload", 32'(qif.index_count), 32'h0000_FFFF);
    qif.arm = 1'b1;
    tick(1);
    qif.arm = 1'b0;
    qif.indexout_in = 1'b1;
    tick(1);
    qif.position_in = -32'sd5;
    tick(1);
    qif.indexout_in = 1'b0;
    qif.position_in = '0;
    push_exp(1'b1, 32'hFFFF_FFFB, 16'd0);
    tick(1);
    check_eq("wrap_count", 32'(qif.index_count), 0);
    tick(2);

    // Asynchronous reset in the middle of WAIT_Z.
    qif.arm = 1'b1;
    tick(1);
    qif.arm = 1'b0;
    qif.indexout_in = 1'b1;
    qif.position_in = 32'd55;
    tick(2);
    check_eq("mid_ie_on", 32'(qif.indexenable_out), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_flags", 32'({qif.indexenable_out, qif.busy, qif.done, qif.timed_out}), 0);
    check_eq("mid_rst_latched", 32'(qif.latched_position), 0);
    check_eq("mid_rst_count", 32'(qif.index_count), 0);
    qif.indexout_in = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(3);
    check_eq("post_rst_idle", 32'({qif.busy, qif.indexenable_out}), 0);

    check_eq("sb_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quadencoder_index_ctrl.md
QUADENCODER_INDEX_CTRL -- requirements
Module: quadencoder_index_ctrl

Interface
REQ-001 Parameter BITS, default 32, width of encoder position.
REQ-002 Parameter TIMEOUT_BITS, default 24, width of search timeout counter.
REQ-003 Parameter RELEASE_CYCLES, default 2, minimum cycles indexenable held low after a search.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 arm  input  1  start index search; sampled high in IDLE only.
REQ-007 abort  input  1  cancel active search.
REQ-008 timeout_cycles  input  TIMEOUT_BITS  search limit in clk cycles; 0 = no timeout.
REQ-009 indexout_in  input  1  index-armed flag from quadrature encoder.
REQ-010 position_in  input  BITS signed  encoder count.
REQ-011 indexenable_out  output  1  index enable to encoder, registered.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse: index reset completed.
REQ-014 timed_out  output  1  one-cycle pulse: search expired.
REQ-015 latched_position  output  BITS signed  encoder count immediately before index reset.
REQ-016 index_count  output  16  completed searches, wraps 0xFFFF -> 0x0000.

Function
REQ-017 FSM states SHALL be IDLE, ARM, WAIT_Z, RELEASE.
REQ-018 IDLE: arm=1 and abort=0 -> ARM next edge; indexenable_out=1 from that edge (1-cycle latency); timeout counter loaded with timeout_cycles.
REQ-019 ARM: indexout_in=1 -> WAIT_Z; indexenable_out stays 1.
REQ-020 WAIT_Z: every cycle, shadow register <= position_in.
REQ-021 WAIT_Z: indexout_in=0 -> next edge: done=1 for one cycle, latched_position <= shadow (value from previous cycle, pre-reset count), index_count += 1, indexenable_out=0, state RELEASE.
REQ-022 Timeout counter SHALL decrement once per cycle in ARM and WAIT_Z when timeout_cycles at load was nonzero; reaching 0 -> timed_out pulse, indexenable_out=0, RELEASE; latched_position and index_count unchanged.
REQ-023 Timeout load value 0 SHALL disable timeout; search waits indefinitely.
REQ-024 abort=1 in ARM or WAIT_Z -> RELEASE next edge, indexenable_out=0, no done, no timed_out.
REQ-025 Simultaneous index fall detection and timeout expiry: index wins (done, not timed_out).
REQ-026 Simultaneous abort and index fall detection: abort wins, no capture.
REQ-027 Simultaneous arm and abort in IDLE: no start.
REQ-028 arm while busy SHALL be ignored, not queued.
REQ-029 RELEASE: indexenable_out=0 for exactly RELEASE_CYCLES cycles, then IDLE; abort and arm ignored.
REQ-030 done and timed_out SHALL never be high in the same cycle.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, indexenable_out=0, busy=0, done=0, timed_out=0, latched_position=0, index_count=0, shadow=0, timeout counter=0.
REQ-032 rst asserted mid-search SHALL drop indexenable_out asynchronously; no done/timed_out emitted; after release block waits in IDLE for arm.

Verification
REQ-033 Normal: timeout_cycles=0, arm pulse; model asserts indexout_in 3 cycles later, position ramps to 1234, indexout_in falls -> done one cycle later, latched_position=1234, index_count=1, indexenable_out low 2 cycles, busy drops.
REQ-034 Timeout: timeout_cycles=10, indexout_in held 0 -> timed_out pulse 10 cycles after ARM entry, index_count=0, latched_position unchanged.
REQ-035 Race: timeout_cycles set so expiry coincides with indexout_in fall -> done=1, timed_out=0, index_count increments.
REQ-036 Abort: arm, enter WAIT_Z, abort=1 -> indexenable_out=0 next edge, no pulses, IDLE after RELEASE_CYCLES; arm during RELEASE ignored.
REQ-037 Wrap: preload 65535 searches (or force) -> next done gives index_count=0.
REQ-038 Reset mid-WAIT_Z: rst asserted asynchronously between edges -> indexenable_out=0 before next edge, all outputs at reset values.
